// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and strobes. Optional bne support: `define MIPS_MC_BNE_EN.
module mips_mc_ctrl #(
    parameter int STATE_W = 4,
    parameter int ALU_W   = 3
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               MemWrite,
    output logic               IorD,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic [ALU_W-1:0]   ALUControl,
    output logic               PCEn,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    localparam logic [STATE_W-1:0] S_FETCH   = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR  = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMRD   = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB   = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWR   = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECUTE = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_ALUWB   = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_BRANCH  = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_ADDIEX  = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_ADDIWB  = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_JUMP    = STATE_W'(11);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3'b000);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3'b001);
    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(3'b010);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(3'b110);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3'b111);

    logic [STATE_W-1:0] next_state;
    logic               illegal_next;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        next_state   = S_FETCH;
        illegal_next = 1'b0;
        case (state)
            S_FETCH:   next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
`ifdef MIPS_MC_BNE_EN
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
`else
                    OP_BEQ:       next_state = S_BRANCH;
`endif
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default: begin
                        next_state   = S_FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  next_state = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   next_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   next_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: next_state = S_ALUWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            default:   next_state = S_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state      <= S_FETCH;
            illegal_op <= 1'b0;
        end else begin
            state      <= next_state;
            illegal_op <= illegal_next;
        end
    end

    // Gated by rst so FETCH's memory request is not issued while reset is held.
    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = '0;
        PCEn       = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    ALUSrcB    = 2'b01;
                    ALUControl = ALU_ADD;
                    IRWrite    = mem_ready;
                    PCEn       = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    ALUControl = ALU_ADD;
                end
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = ALU_ADD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    case (Funct)
                        6'b100010: ALUControl = ALU_SUB;
                        6'b100100: ALUControl = ALU_AND;
                        6'b100101: ALUControl = ALU_OR;
                        6'b101010: ALUControl = ALU_SLT;
                        default:   ALUControl = ALU_ADD;
                    endcase
                end
                S_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = ALU_SUB;
                    PCSrc      = 2'b01;
`ifdef MIPS_MC_BNE_EN
                    PCEn       = (Op == OP_BNE) ? ~Zero : Zero;
`else
                    PCEn       = Zero;
`endif
                end
                S_ADDIWB:  RegWrite = 1'b1;
                S_JUMP: begin
                    PCSrc = 2'b10;
                    PCEn  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized self-checking bench for mips_mc_ctrl: each instruction is expanded into
// a list of expected per-cycle control steps and compared against the DUT every cycle.
module tb_mips_mc_ctrl;

    logic       CLK = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] Op = '0;
    logic [5:0] Funct = '0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic       PCEn, illegal_op;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    mips_mc_ctrl #(.STATE_W(4), .ALU_W(3)) dut (
        .CLK(CLK), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl), .PCEn(PCEn),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 CLK = ~CLK;

    typedef enum {PC_OFF, PC_ON, PC_RDY, PC_Z, PC_NZ} pcen_e;
    typedef struct {
        string     name;
        bit        mem_req, mem_write, iord, irw, regdst, memtoreg, regwrite, srca;
        bit [1:0]  srcb, pcsrc;
        bit [2:0]  alu;
        pcen_e     pcen;
        bit        waits;
    } step_t;

    step_t plan[$];
    bit    exp_illegal = 1'b0;

    localparam bit [2:0] A_ADD = 3'b010;
    localparam bit [2:0] A_SUB = 3'b110;

    function automatic step_t blank(string name);
        step_t s;
        s.name = name; s.mem_req = 0; s.mem_write = 0; s.iord = 0; s.irw = 0;
        s.regdst = 0; s.memtoreg = 0; s.regwrite = 0; s.srca = 0;
        s.srcb = 2'b00; s.pcsrc = 2'b00; s.alu = 3'b000; s.pcen = PC_OFF; s.waits = 0;
        return s;
    endfunction

    function automatic bit [2:0] alu_of_funct(bit [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    task automatic push_alu(string name, bit srca, bit [1:0] srcb, bit [2:0] alu);
        step_t s = blank(name);
        s.srca = srca; s.srcb = srcb; s.alu = alu;
        plan.push_back(s);
    endtask

    task automatic push_mem(string name, bit wr);
        step_t s = blank(name);
        s.mem_req = 1; s.iord = 1; s.mem_write = wr; s.waits = 1;
        plan.push_back(s);
    endtask

    task automatic push_wb(string name, bit regdst, bit memtoreg);
        step_t s = blank(name);
        s.regdst = regdst; s.memtoreg = memtoreg; s.regwrite = 1;
        plan.push_back(s);
    endtask

    task automatic push_branch(pcen_e mode);
        step_t s = blank("branch");
        s.srca = 1; s.alu = A_SUB; s.pcsrc = 2'b01; s.pcen = mode;
        plan.push_back(s);
    endtask

    // Expands one instruction into its expected control steps; returns 1 if it is illegal.
    task automatic build(input bit [5:0] op, input bit [5:0] funct, output bit ill);
        step_t s;
        plan.delete();
        ill = 0;
        s = blank("fetch");
        s.mem_req = 1; s.srcb = 2'b01; s.alu = A_ADD; s.irw = 1; s.pcen = PC_RDY; s.waits = 1;
        plan.push_back(s);
        push_alu("decode", 0, 2'b11, A_ADD);
        case (op)
            6'b100011: begin
                push_alu("memadr", 1, 2'b10, A_ADD);
                push_mem("memrd", 0);
                push_wb("memwb", 0, 1);
            end
            6'b101011: begin
                push_alu("memadr", 1, 2'b10, A_ADD);
                push_mem("memwr", 1);
            end
            6'b000000: begin
                push_alu("execute", 1, 2'b00, alu_of_funct(funct));
                push_wb("aluwb", 1, 0);
            end
            6'b000100: push_branch(PC_Z);
`ifdef MIPS_MC_BNE_EN
            6'b000101: push_branch(PC_NZ);
`endif
            6'b001000: begin
                push_alu("addiex", 1, 2'b10, A_ADD);
                push_wb("addiwb", 0, 0);
            end
            6'b000010: begin
                s = blank("jump");
                s.pcsrc = 2'b10; s.pcen = PC_ON;
                plan.push_back(s);
            end
            default: ill = 1;
        endcase
    endtask

    function automatic logic [16:0] exp_vec(step_t s, bit rdy, bit z, bit ill);
        bit pc;
        case (s.pcen)
            PC_OFF:  pc = 0;
            PC_ON:   pc = 1;
            PC_RDY:  pc = rdy;
            PC_Z:    pc = z;
            default: pc = ~z;
        endcase
        return {s.mem_req, s.mem_write, s.iord, s.irw & rdy, s.regdst, s.memtoreg,
                s.regwrite, s.srca, s.srcb, s.pcsrc, s.alu, pc, ill};
    endfunction

    function automatic logic [16:0] act_vec();
        return {mem_req, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, PCSrc, ALUControl, PCEn, illegal_op};
    endfunction

    // Runs one instruction from FETCH; entry and exit are at posedge+1.
    // fetch_low/mem_low: cycles of mem_ready=0 before the ready; negative means random.
    task automatic run_instr(input bit [5:0] op, input bit [5:0] funct, input int fetch_low,
                             input int mem_low, input int zero_mode, output int cycles,
                             output int n_regw, output int n_memw, output int n_pcen);
        bit ill, rdy, z;
        int waited, low;
        step_t s;
        logic [16:0] e, a;
        build(op, funct, ill);
        Op = op;
        Funct = funct;
        cycles = 0; n_regw = 0; n_memw = 0; n_pcen = 0; waited = 0;
        while (plan.size() > 0 && cycles < 300) begin
            s = plan[0];
            low = (s.name == "fetch") ? fetch_low : mem_low;
            if (s.waits)
                rdy = (low < 0) ? 1'($urandom_range(0, 1)) : (waited >= low);
            else
                rdy = 1'($urandom_range(0, 1));
            z = (zero_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(zero_mode);
            mem_ready = rdy;
            Zero = z;
            @(negedge CLK);
            e = exp_vec(s, rdy, z, exp_illegal);
            a = act_vec();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s op=%b funct=%b rdy=%0b zero=%0b: got %b want %b", s.name,
                         op, funct, rdy, z, a, e);
            end
            exp_illegal = 0;
            n_regw += int'(RegWrite === 1'b1);
            n_memw += int'(MemWrite === 1'b1);
            n_pcen += int'(PCEn === 1'b1);
            @(posedge CLK);
            #1;
            cycles++;
            if (!s.waits || rdy) begin
                void'(plan.pop_front());
                waited = 0;
            end else begin
                waited++;
            end
        end
        if (plan.size() > 0) begin
            total++;
            bad++;
            $display("FAIL timeout op=%b: got %0d steps left want 0", op, plan.size());
            plan.delete();
        end
        exp_illegal = ill;
    endtask

    task automatic expect_int(string name, int got, int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        int c, r, m, p;
        rst = 0;
        mem_ready = 1;
        Op = 6'b101011;
        for (int i = 0; i < 2; i++) begin
            Zero = 1'(i);
            @(negedge CLK);
            total++;
            if (act_vec() !== 17'b0) begin
                bad++;
                $display("FAIL reset_outputs: got %b want %b", act_vec(), 17'b0);
            end
        end
        @(posedge CLK);
        #1;
        rst = 1;
        exp_illegal = 0;
        run_instr(6'b000000, 6'b100000, 3, 0, -1, c, r, m, p);
        expect_int("reset_idle_cycles", c, 7);
        expect_int("reset_idle_pcen", p, 1);
    endtask

    task automatic test_cycle_counts();
        bit [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
        int want[6] = '{5, 4, 4, 4, 3, 3};
        int c, r, m, p;
        for (int i = 0; i < 6; i++) begin
            run_instr(ops[i], 6'b100000, 0, 0, -1, c, r, m, p);
            expect_int($sformatf("cycles_op%b", ops[i]), c, want[i]);
        end
    endtask

    task automatic test_lw();
        int c, r, m, p;
        run_instr(6'b100011, 6'b000000, 0, 0, -1, c, r, m, p);
        expect_int("lw_regwrite_cycles", r, 1);
        expect_int("lw_memwrite_cycles", m, 0);
    endtask

    task automatic test_sw_wait();
        int c, r, m, p;
        run_instr(6'b101011, 6'b000000, 0, 2, -1, c, r, m, p);
        expect_int("sw_memwrite_cycles", m, 3);
        expect_int("sw_regwrite_cycles", r, 0);
        expect_int("sw_cycles", c, 6);
    endtask

    task automatic test_rtype();
        int c, r, m, p;
        run_instr(6'b000000, 6'b100010, 0, 0, -1, c, r, m, p);
        expect_int("rtype_sub_regwrite", r, 1);
        run_instr(6'b000000, 6'b101010, 0, 0, -1, c, r, m, p);
        expect_int("rtype_slt_regwrite", r, 1);
    endtask

    task automatic test_branch();
        int c, r, m, p;
        run_instr(6'b000100, 6'b000000, 0, 0, 1, c, r, m, p);
        expect_int("beq_taken_pcen", p, 2);
        run_instr(6'b000100, 6'b000000, 0, 0, 0, c, r, m, p);
        expect_int("beq_not_taken_pcen", p, 1);
        run_instr(6'b000101, 6'b000000, 0, 0, 0, c, r, m, p);
`ifdef MIPS_MC_BNE_EN
        expect_int("bne_taken_pcen", p, 2);
        run_instr(6'b000101, 6'b000000, 0, 0, 1, c, r, m, p);
        expect_int("bne_not_taken_pcen", p, 1);
`else
        expect_int("bne_illegal_cycles", c, 2);
        expect_int("bne_illegal_pcen", p, 1);
`endif
        run_instr(6'b000010, 6'b000000, 0, 0, -1, c, r, m, p);
    endtask

    task automatic test_random();
        bit [5:0] legal[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
        bit [5:0] op;
        int c, r, m, p;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
            else op = legal[$urandom_range(0, 5)];
            run_instr(op, 6'($urandom_range(0, 63)), -1, -1, -1, c, r, m, p);
        end
    endtask

    task automatic test_async_reset();
        int c, r, m, p;
        Op = 6'b101011;
        mem_ready = 1;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        mem_ready = 0;
        @(negedge CLK);
        total++;
        if ({mem_req, MemWrite, IorD} !== 3'b111) begin
            bad++;
            $display("FAIL memwr_before_reset: got %b want %b", {mem_req, MemWrite, IorD}, 3'b111);
        end
        #2 rst = 0;
        #1;
        total++;
        if (act_vec() !== 17'b0) begin
            bad++;
            $display("FAIL async_reset_mid_sw: got %b want %b", act_vec(), 17'b0);
        end
        @(posedge CLK);
        #1;
        rst = 1;
        exp_illegal = 0;
        run_instr(6'b000010, 6'b000000, 1, 0, -1, c, r, m, p);
        expect_int("after_reset_jump_cycles", c, 4);

        run_instr(6'b111111, 6'b000000, 0, 0, -1, c, r, m, p);
        mem_ready = 0;
        #1;
        total++;
        if (illegal_op !== 1'b1) begin
            bad++;
            $display("FAIL illegal_pulse: got %b want 1", illegal_op);
        end
        rst = 0;
        #1;
        total++;
        if (illegal_op !== 1'b0) begin
            bad++;
            $display("FAIL illegal_async_clear: got %b want 0", illegal_op);
        end
        @(posedge CLK);
        #1;
        rst = 1;
        exp_illegal = 0;
        run_instr(6'b001000, 6'b000000, 0, 0, -1, c, r, m, p);
        expect_int("after_illegal_reset_cycles", c, 4);
    endtask

    initial begin
        test_reset();
        test_cycle_counts();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_branch();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
